// File: rtl/ext_bus_pkg.sv
// Shared constants, FSM state type and byte-lane merge
// for the external-bus register bank.
package ext_bus_pkg;

  localparam int unsigned STS_BASE_W = 32'h40;
  localparam int unsigned ID_W       = 32'hF0;
  localparam int unsigned IRQ_PEND_W = 32'hF1;
  localparam int unsigned IRQ_MASK_W = 32'hF2;
  localparam int unsigned ERR_CNT_W  = 32'hF3;

  localparam int MAX_DW = 64;
  localparam int MAX_BE = MAX_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_REL
  } bus_state_e;

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_v,
    input logic [MAX_DW-1:0] new_v,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ext_bus_irq_ctrl.sv
// Interrupt controller: rising-edge detect, W1C pending,
// mask register, registered level irq output.
module ext_bus_irq_ctrl
  import ext_bus_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             pend_clr_en,
  input  logic [N_IRQ-1:0] pend_clr,
  input  logic             mask_wr_en,
  input  logic [N_IRQ-1:0] mask_wd,
  output logic [N_IRQ-1:0] pend,
  output logic [N_IRQ-1:0] mask,
  output logic             irq
);

  logic [N_IRQ-1:0] src_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;

  assign rise = irq_src & ~src_q;
  assign clr  = pend_clr_en ? pend_clr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
      irq   <= 1'b0;
    end else begin
      src_q <= irq_src;
      // a new edge beats a simultaneous clear
      pend  <= (pend & ~clr) | rise;
      if (mask_wr_en) mask <= mask_wd;
      irq   <= |(pend & mask);
    end
  end

endmodule

// File: rtl/ext_bus_reg_bank.sv
// Bridge-side register bank: ctrl regs, status regs, ID,
// IRQ pend/mask, saturating error counter, delayed ack.
module ext_bus_reg_bank
  import ext_bus_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter int          N_CTRL    = 8,
  parameter int          N_STS     = 8,
  parameter int          N_IRQ     = 4,
  parameter int          ACK_DELAY = 1,
  parameter logic [31:0] ID_VALUE  = 32'h5C7A_0001
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [ADDR_W-1:0]        bus_address,
  input  logic                     bus_enable,
  input  logic [DATA_W/8-1:0]      bus_byte_enable,
  input  logic                     bus_rw,
  input  logic [DATA_W-1:0]        bus_write_data,
  output logic [DATA_W-1:0]        bus_read_data,
  output logic                     bus_acknowledge,
  output logic                     bus_irq,
  output logic [N_CTRL*DATA_W-1:0] ctrl_out,
  output logic [N_CTRL-1:0]        ctrl_wr_strobe,
  input  logic [N_STS*DATA_W-1:0]  sts_in,
  input  logic [N_IRQ-1:0]         irq_src
);

  localparam int BE_W = DATA_W / 8;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n,
    input logic [BE_W-1:0]   b
  );
    logic [MAX_DW-1:0] r;
    r = lane_merge(MAX_DW'(o), MAX_DW'(n), MAX_BE'(b));
    return r[DATA_W-1:0];
  endfunction

  bus_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-3:0] cap_widx;
  logic              cap_rw;
  logic [BE_W-1:0]   cap_be;
  logic [DATA_W-1:0] cap_wd;

  logic [31:0] widx;
  logic is_ctrl, is_sts, is_id;
  logic is_pend, is_mask, is_err;
  logic mapped, ack, wr_go;

  logic [DATA_W-1:0] ctrl_q [N_CTRL];
  logic [15:0]       err_q;
  logic [DATA_W-1:0] rd_ctrl, rd_sts, rd;
  logic [DATA_W-1:0] wd_lanes, mask_mrg;
  logic [N_IRQ-1:0]  irq_pend, irq_mask;
  logic              tie_unused;

  assign widx    = 32'(cap_widx);
  assign is_ctrl = widx < N_CTRL;
  assign is_sts  = (widx >= STS_BASE_W) &&
                   (widx < STS_BASE_W + N_STS);
  assign is_id   = widx == ID_W;
  assign is_pend = widx == IRQ_PEND_W;
  assign is_mask = widx == IRQ_MASK_W;
  assign is_err  = widx == ERR_CNT_W;
  assign mapped  = is_ctrl | is_sts | is_id |
                   is_pend | is_mask | is_err;

  assign ack   = state_q == ST_ACK;
  assign wr_go = ack & ~cap_rw;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_enable) begin
          cnt_d   = 4'(ACK_DELAY - 1);
          state_d = (ACK_DELAY > 1) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!bus_enable) state_d = ST_IDLE;
        else if (cnt_q <= 4'd1) state_d = ST_ACK;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ACK:  state_d = ST_REL;
      ST_REL:  if (!bus_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cap_widx       <= '0;
      cap_rw         <= 1'b0;
      cap_be         <= '0;
      cap_wd         <= '0;
      ctrl_q         <= '{default: '0};
      ctrl_wr_strobe <= '0;
      err_q          <= '0;
    end else begin
      ctrl_wr_strobe <= '0;
      if (state_q == ST_IDLE && bus_enable) begin
        cap_widx <= bus_address[ADDR_W-1:2];
        cap_rw   <= bus_rw;
        cap_be   <= bus_byte_enable;
        cap_wd   <= bus_write_data;
      end
      if (wr_go && is_ctrl) begin
        for (int k = 0; k < N_CTRL; k++) begin
          if (widx == k) begin
            ctrl_q[k] <= merge(ctrl_q[k], cap_wd, cap_be);
            ctrl_wr_strobe[k] <= 1'b1;
          end
        end
      end
      if (ack && !mapped) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end else if (wr_go && is_err) begin
        err_q <= '0;
      end
    end
  end

  for (genvar k = 0; k < N_CTRL; k++) begin : g_out
    assign ctrl_out[k*DATA_W +: DATA_W] = ctrl_q[k];
  end

  always_comb begin
    rd_ctrl = '0;
    for (int k = 0; k < N_CTRL; k++) begin
      if (widx == k) rd_ctrl = ctrl_q[k];
    end
    rd_sts = '0;
    for (int k = 0; k < N_STS; k++) begin
      if (widx == STS_BASE_W + k)
        rd_sts = sts_in[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd = '0;
    if (ack && cap_rw) begin
      unique case (1'b1)
        is_ctrl: rd = rd_ctrl;
        is_sts:  rd = rd_sts;
        is_id:   rd = DATA_W'(ID_VALUE);
        is_pend: rd = DATA_W'(irq_pend);
        is_mask: rd = DATA_W'(irq_mask);
        is_err:  rd = DATA_W'(err_q);
        default: rd = '0;
      endcase
    end
  end

  assign bus_read_data   = rd;
  assign bus_acknowledge = ack;

  assign wd_lanes = merge('0, cap_wd, cap_be);
  assign mask_mrg = merge(DATA_W'(irq_mask), cap_wd, cap_be);
  assign tie_unused = ^{bus_address[1:0],
                        wd_lanes, mask_mrg};

  ext_bus_irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq (
    .clk        (clk_clk),
    .rst        (reset_reset),
    .irq_src    (irq_src),
    .pend_clr_en(wr_go & is_pend),
    .pend_clr   (wd_lanes[N_IRQ-1:0]),
    .mask_wr_en (wr_go & is_mask),
    .mask_wd    (mask_mrg[N_IRQ-1:0]),
    .pend       (irq_pend),
    .mask       (irq_mask),
    .irq        (bus_irq)
  );

endmodule

// File: tb/tb_ext_bus_reg_bank.sv
// Bench for ext_bus_reg_bank: cycle model plus
// directed literal checks on ACK_DELAY=3 and 4 instances.
module tb_ext_bus_reg_bank;

  localparam int AD3 = 3;
  localparam int NONE = -100;

  logic clk;
  logic rst;
  int   cyc = -1;

  logic [9:0]   addr;
  logic         en, rw;
  logic [3:0]   be;
  logic [31:0]  wd, rd;
  logic         ack, irq;
  logic [255:0] ctrl;
  logic [7:0]   strobe;

  logic [9:0]   b4_addr;
  logic         b4_en, b4_rw;
  logic [3:0]   b4_be;
  logic [31:0]  b4_wd, b4_rd;
  logic         b4_ack, b4_irq;
  logic [255:0] b4_ctrl;
  logic [7:0]   b4_strobe;

  logic [255:0] sts;
  logic [3:0]   irq_src;

  int n_cmp = 0;
  int n_fail = 0;

  logic [9:0]  tx_addr;
  logic        tx_rw;
  logic [3:0]  tx_be;
  logic [31:0] tx_wd;
  int          tx_ack = NONE;
  int          src_pulse_at = NONE;

  logic [255:0] snap_ctrl;
  logic [7:0]   snap_strobe;
  logic         snap_irq;

  ext_bus_reg_bank #(.ACK_DELAY(AD3)) dut3 (
    .clk_clk(clk), .reset_reset(rst),
    .bus_address(addr), .bus_enable(en),
    .bus_byte_enable(be), .bus_rw(rw),
    .bus_write_data(wd), .bus_read_data(rd),
    .bus_acknowledge(ack), .bus_irq(irq),
    .ctrl_out(ctrl), .ctrl_wr_strobe(strobe),
    .sts_in(sts), .irq_src(irq_src)
  );

  ext_bus_reg_bank #(.ACK_DELAY(4)) dut4 (
    .clk_clk(clk), .reset_reset(rst),
    .bus_address(b4_addr), .bus_enable(b4_en),
    .bus_byte_enable(b4_be), .bus_rw(b4_rw),
    .bus_write_data(b4_wd), .bus_read_data(b4_rd),
    .bus_acknowledge(b4_ack), .bus_irq(b4_irq),
    .ctrl_out(b4_ctrl), .ctrl_wr_strobe(b4_strobe),
    .sts_in(sts), .irq_src(irq_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    irq_src = {3'b000, cyc == src_pulse_at};
  end

  task automatic chk(input string nm,
                     input logic [255:0] a,
                     input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, a, e);
    end
  endtask

  function automatic logic [31:0] lanes(
    input logic [31:0] o, input logic [31:0] n,
    input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++)
      if (b[l]) r[l*8 +: 8] = n[l*8 +: 8];
    return r;
  endfunction

  function automatic bit mapped(input int w);
    return (w < 8) || (w >= 64 && w < 72) ||
           (w >= 240 && w <= 243);
  endfunction

  // model state, as seen in the current cycle
  logic [31:0] m_ctrl [8];
  logic [3:0]  m_pend, m_mask, m_hist;
  logic [15:0] m_err;
  logic        m_irq;
  logic [7:0]  m_strobe;
  logic        p_rst = 1'b1;
  logic [3:0]  p_src = 4'h0;

  function automatic logic [31:0] m_read(input int w);
    if (w < 8) return m_ctrl[w];
    if (w >= 64 && w < 72) return sts[(w-64)*32 +: 32];
    if (w == 240) return 32'h5C7A_0001;
    if (w == 241) return {28'h0, m_pend};
    if (w == 242) return {28'h0, m_mask};
    if (w == 243) return {16'h0, m_err};
    return 32'h0;
  endfunction

  always @(negedge clk) begin : model
    logic [3:0]   edges, clr;
    logic [31:0]  tmp, e_rd;
    logic [255:0] e_ctrl;
    logic         e_ack, pa;
    int           w;
    pa = (cyc - 1 == tx_ack);
    w  = int'(tx_addr >> 2);
    if (p_rst) begin
      for (int k = 0; k < 8; k++) m_ctrl[k] = 32'h0;
      m_pend = 0; m_mask = 0; m_hist = 0;
      m_err = 0; m_irq = 0; m_strobe = 0;
    end else begin
      m_irq = |(m_pend & m_mask);
      m_strobe = 0;
      edges = p_src & ~m_hist;
      m_hist = p_src;
      clr = 0;
      if (pa && !tx_rw) begin
        if (w < 8) begin
          m_ctrl[w] = lanes(m_ctrl[w], tx_wd, tx_be);
          m_strobe[w] = 1'b1;
        end else if (w == 241) begin
          tmp = lanes(32'h0, tx_wd, tx_be);
          clr = tmp[3:0];
        end else if (w == 242) begin
          tmp = lanes({28'h0, m_mask}, tx_wd, tx_be);
          m_mask = tmp[3:0];
        end else if (w == 243) begin
          m_err = 0;
        end
      end
      if (pa && !mapped(w) && m_err != 16'hFFFF)
        m_err = m_err + 16'd1;
      m_pend = (m_pend & ~clr) | edges;
    end
    e_ack = (cyc == tx_ack);
    e_rd = (e_ack && tx_rw) ? m_read(w) : 32'h0;
    for (int k = 0; k < 8; k++)
      e_ctrl[k*32 +: 32] = m_ctrl[k];
    chk("m_ack", 256'(ack), 256'(e_ack));
    chk("m_rdata", 256'(rd), 256'(e_rd));
    chk("m_irq", 256'(irq), 256'(m_irq));
    chk("m_ctrl", ctrl, e_ctrl);
    chk("m_strobe", 256'(strobe), 256'(m_strobe));
    p_rst = rst;
    p_src = irq_src;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns two cycles after acknowledge; snapshots the
  // cycle right after acknowledge
  task automatic xfer(input logic r, input logic [9:0] a,
                      input logic [3:0] b,
                      input logic [31:0] d,
                      output logic [31:0] rdv,
                      output int ac);
    tx_addr = a; tx_rw = r; tx_be = b; tx_wd = d;
    tx_ack = cyc + AD3;
    addr = a; rw = r; be = b; wd = d; en = 1'b1;
    ac = NONE;
    rdv = 32'h0;
    for (int i = 0; i < 20 && ac == NONE; i++) begin
      tick();
      if (ack) begin
        ac = cyc;
        rdv = rd;
      end
    end
    en = 1'b0;
    if (ac == NONE) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout addr=%0h", a);
    end
    tick();
    snap_ctrl = ctrl;
    snap_strobe = strobe;
    snap_irq = irq;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v;
    int          ac, t0;
    logic        seen_a, seen_s;
    rst = 1'b1;
    en = 0; rw = 0; addr = 0; be = 0; wd = 0;
    b4_en = 0; b4_rw = 0; b4_addr = 0;
    b4_be = 0; b4_wd = 0;
    sts = '0;
    for (int k = 0; k < 8; k++)
      sts[k*32 +: 32] = 32'h1000_0000 + k;
    sts[63:32] = 32'hDEAD_BEEF;

    tick();
    tick();
    chk("rst_ack", 256'(ack), 256'(0));
    chk("rst_rdata", 256'(rd), 256'(0));
    chk("rst_irq", 256'(irq), 256'(0));
    chk("rst_ctrl", ctrl, 256'(0));
    chk("rst_strobe", 256'(strobe), 256'(0));
    tick();
    rst = 1'b0;
    while (cyc < 10) tick();

    xfer(0, 10'h008, 4'b0011, 32'hA5A5_1234, v, ac);
    chk("wr_ack_cycle", 256'(ac), 256'(13));
    chk("wr_ctrl2", 256'(snap_ctrl[95:64]),
        256'(32'h0000_1234));
    chk("wr_strobe", 256'(snap_strobe), 256'(8'b100));
    chk("wr_strobe_off", 256'(strobe), 256'(0));

    xfer(1, 10'h104, 4'hF, 32'h0, v, ac);
    chk("rd_sts1", 256'(v), 256'(32'hDEAD_BEEF));
    xfer(1, 10'h3C0, 4'hF, 32'h0, v, ac);
    chk("rd_id", 256'(v), 256'(32'h5C7A_0001));

    xfer(1, 10'h200, 4'hF, 32'h0, v, ac);
    chk("rd_unmapped", 256'(v), 256'(0));
    xfer(0, 10'h200, 4'hF, 32'hFFFF_FFFF, v, ac);
    xfer(1, 10'h3CC, 4'hF, 32'h0, v, ac);
    chk("err_cnt_2", 256'(v), 256'(2));
    xfer(0, 10'h3CC, 4'h1, 32'h0, v, ac);
    xfer(1, 10'h3CC, 4'hF, 32'h0, v, ac);
    chk("err_cnt_clr", 256'(v), 256'(0));

    tx_ack = NONE;
    addr = 10'h008; rw = 0; be = 4'hF;
    wd = 32'h0BAD_0BAD; en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    repeat (5) tick();
    xfer(1, 10'h008, 4'hF, 32'h0, v, ac);
    chk("abort3_ctrl2", 256'(v), 256'(32'h0000_1234));

    xfer(0, 10'h3C8, 4'hF, 32'h1, v, ac);
    src_pulse_at = cyc + 1;
    tick();
    tick();
    chk("irq_edge_p1", 256'(irq), 256'(0));
    tick();
    chk("irq_edge_p2", 256'(irq), 256'(1));
    src_pulse_at = cyc + AD3;
    xfer(0, 10'h3C4, 4'hF, 32'h1, v, ac);
    xfer(1, 10'h3C4, 4'hF, 32'h0, v, ac);
    chk("w1c_vs_edge", 256'(v), 256'(1));
    xfer(0, 10'h3C4, 4'hF, 32'h1, v, ac);
    chk("w1c_irq_c1", 256'(snap_irq), 256'(1));
    chk("w1c_irq_c2", 256'(irq), 256'(0));
    xfer(1, 10'h3C4, 4'hF, 32'h0, v, ac);
    chk("w1c_pend", 256'(v), 256'(0));

    b4_addr = 10'h004; b4_rw = 0; b4_be = 4'hF;
    b4_wd = 32'h1122_3344; b4_en = 1'b1;
    seen_a = 0; seen_s = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) b4_en = 1'b0;
      if (b4_ack) seen_a = 1;
      if (b4_strobe != 0) seen_s = 1;
    end
    chk("abort4_ack", 256'(seen_a), 256'(0));
    chk("abort4_strobe", 256'(seen_s), 256'(0));
    chk("abort4_ctrl1", 256'(b4_ctrl[63:32]), 256'(0));
    t0 = cyc;
    b4_en = 1'b1;
    ac = NONE;
    for (int i = 0; i < 12 && ac == NONE; i++) begin
      tick();
      if (b4_ack) ac = cyc;
    end
    b4_en = 1'b0;
    tick();
    chk("d4_ack_cycle", 256'(ac), 256'(t0 + 4));
    chk("d4_ctrl1", 256'(b4_ctrl[63:32]),
        256'(32'h1122_3344));
    chk("d4_strobe", 256'(b4_strobe), 256'(8'b10));
    tick();

    tx_ack = NONE;
    addr = 10'h00C; rw = 0; be = 4'hF;
    wd = 32'h7777_7777; en = 1'b1;
    tick();
    rst = 1'b1;
    en = 1'b0;
    tick();
    chk("mid_rst_ack", 256'(ack), 256'(0));
    chk("mid_rst_ctrl", ctrl, 256'(0));
    chk("mid_rst_strobe", 256'(strobe), 256'(0));
    chk("mid_rst_irq", 256'(irq), 256'(0));
    chk("mid_rst_rdata", 256'(rd), 256'(0));
    rst = 1'b0;
    tick();
    xfer(0, 10'h014, 4'hF, 32'hCAFE_F00D, v, ac);
    chk("post_rst_ctrl5", 256'(snap_ctrl[191:160]),
        256'(32'hCAFE_F00D));
    xfer(1, 10'h014, 4'hF, 32'h0, v, ac);
    chk("post_rst_rd5", 256'(v), 256'(32'hCAFE_F00D));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
